// File: rtl/wb_mru_pkg.sv
// Shared types and lane-steering helpers for the Wishbone memory request unit.
package wb_mru_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_RSV = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  function automatic logic [3:0] sel_gen(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_B:    sel_gen = 4'b0001 << a;
      SZ_H:    sel_gen = a[1] ? 4'b1100 : 4'b0011;
      SZ_W:    sel_gen = 4'b1111;
      default: sel_gen = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] wdata_steer(input size_e sz, input logic [31:0] d);
    case (sz)
      SZ_B:    wdata_steer = {4{d[7:0]}};
      SZ_H:    wdata_steer = {2{d[15:0]}};
      default: wdata_steer = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then zero-extend to the access size.
  function automatic logic [31:0] lane_align(input logic [31:0] dat, input size_e sz,
                                             input logic [1:0] a);
    logic [31:0] sh;
    sh = dat >> {a, 3'b000};
    case (sz)
      SZ_B:    lane_align = {24'h0, sh[7:0]};
      SZ_H:    lane_align = {16'h0, sh[15:0]};
      default: lane_align = sh;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_H:    misaligned = a[0];
      SZ_W:    misaligned = |a;
      SZ_RSV:  misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// N-way request arbiter: fixed priority (index 0 highest) or round-robin from ptr.
module wb_rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter bit          RR = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [N-1:0]                           req_i,
  input  logic                                   adv_i,
  output logic [N-1:0]                           gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   idx_o,
  output logic                                   vld_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] c;
  int unsigned   t;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = '0;
    t     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      t = RR ? (32'(ptr_q) + k) % N : k;
      c = IW'(t);
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && vld_o) ptr_d = (32'(idx_o) + 1 >= N) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_mru_arb.sv
// N-channel memory request unit: arbitrates CPU request channels onto one
// Wishbone classic master port with lane steering, timeout and error reporting.
module wb_mru_arb
  import wb_mru_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter bit          ARB_RR      = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_CH-1:0]      req_en,
  input  logic [N_CH-1:0]      req_we,
  input  logic [2*N_CH-1:0]    req_size,
  input  logic [32*N_CH-1:0]   req_addr,
  input  logic [32*N_CH-1:0]   req_wdata,
  output logic [N_CH-1:0]      req_stl,
  output logic [N_CH-1:0]      req_ack,
  output logic [N_CH-1:0]      req_err,
  output logic [32*N_CH-1:0]   req_rdata,
  output logic [29:0]          adr_o,
  output logic [31:0]          dat_o,
  output logic [3:0]           sel_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  input  logic [31:0]          dat_i,
  input  logic                 ack_i,
  input  logic                 err_i
);

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [N_CH-1:0][1:0]  size_a;
  logic [N_CH-1:0][31:0] addr_a, wdata_a;
  logic [N_CH-1:0][31:0] rdata_q;

  state_e          state_q;
  logic [N_CH-1:0] gnt_q, ack_q, err_q;
  logic [IW-1:0]   gidx_q;
  logic [1:0]      alo_q;
  size_e           size_q;
  logic [TW-1:0]   tcnt_q;

  logic [N_CH-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;
  logic            timeout;

  size_e           c_size;
  logic [31:0]     c_addr, c_wdata;
  logic            c_we;

  assign size_a    = req_size;
  assign addr_a    = req_addr;
  assign wdata_a   = req_wdata;
  assign req_rdata = rdata_q;
  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign req_stl   = req_en & ~ack_q;

  wb_rr_arbiter #(.N(N_CH), .RR(ARB_RR)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_en),
    .adv_i  (state_q == IDLE),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  always_comb begin
    c_size  = size_e'(size_a[arb_idx]);
    c_addr  = addr_a[arb_idx];
    c_wdata = wdata_a[arb_idx];
    c_we    = req_we[arb_idx];
  end

  assign timeout = (TIMEOUT_CYC != 0) && (tcnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      gidx_q  <= '0;
      alo_q   <= '0;
      size_q  <= SZ_B;
      tcnt_q  <= '0;
      rdata_q <= '0;
      adr_o   <= '0;
      dat_o   <= '0;
      sel_o   <= '0;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        IDLE: if (arb_vld) begin
          gnt_q  <= arb_gnt;
          gidx_q <= arb_idx;
          alo_q  <= c_addr[1:0];
          size_q <= c_size;
          adr_o  <= c_addr[31:2];
          we_o   <= c_we;
          sel_o  <= sel_gen(c_size, c_addr[1:0]);
          dat_o  <= wdata_steer(c_size, c_wdata);
          tcnt_q <= '0;
          // Bad size/alignment is answered directly without touching the bus.
          if (misaligned(c_size, c_addr[1:0])) begin
            state_q <= RESP;
            ack_q   <= arb_gnt;
            err_q   <= arb_gnt;
          end else begin
            state_q <= BUS;
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
          end
        end
        BUS: begin
          if (ack_i || err_i || timeout) begin
            state_q <= RESP;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            ack_q   <= gnt_q;
            if (err_i || !ack_i) err_q <= gnt_q;
            else if (!we_o)      rdata_q[gidx_q] <= lane_align(dat_i, size_q, alo_q);
          end else if (tcnt_q != '1) begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mru_arb.sv
// Directed self-checking bench for wb_mru_arb (3 channels, fixed and round-robin instances).
module tb_wb_mru_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Fixed-priority instance with controllable slave.
  logic [2:0]  req_en, req_we;
  logic [5:0]  req_size;
  logic [95:0] req_addr, req_wdata;
  logic [2:0]  req_stl, req_ack, req_err;
  logic [95:0] req_rdata;
  logic [29:0] adr_o;
  logic [31:0] dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o, stb_o, we_o, ack_i, err_i;
  logic        ack_en, err_en;

  assign ack_i = ack_en & cyc_o & stb_o;
  assign err_i = err_en & cyc_o & stb_o;

  wb_mru_arb #(.N_CH(3), .ARB_RR(1'b0), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_en(req_en), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_stl(req_stl), .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .we_o(we_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  // Round-robin instance behind a zero-wait slave.
  logic [2:0]  b_req_en;
  logic [2:0]  b_stl, b_ack, b_err;
  logic [95:0] b_rdata;
  logic [29:0] b_adr;
  logic [31:0] b_dat_o;
  logic [3:0]  b_sel;
  logic        b_cyc, b_stb, b_we, b_ack_i;

  assign b_ack_i = b_cyc & b_stb;

  wb_mru_arb #(.N_CH(3), .ARB_RR(1'b1), .TIMEOUT_CYC(4)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .req_en(b_req_en), .req_we(3'b000), .req_size(6'b101010),
    .req_addr(96'h0), .req_wdata(96'h0),
    .req_stl(b_stl), .req_ack(b_ack), .req_err(b_err), .req_rdata(b_rdata),
    .adr_o(b_adr), .dat_o(b_dat_o), .sel_o(b_sel), .cyc_o(b_cyc), .stb_o(b_stb),
    .we_o(b_we), .dat_i(32'h0), .ack_i(b_ack_i), .err_i(1'b0)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int unsigned ch, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    req_we[ch]              = we;
    req_size[2*ch +: 2]     = sz;
    req_addr[32*ch +: 32]   = a;
    req_wdata[32*ch +: 32]  = d;
    req_en[ch]              = 1'b1;
  endtask

  logic [2:0]  seq [4];
  int unsigned when [4];
  int unsigned k, cnt;
  logic        found;
  logic [2:0]  err_seen;

  initial begin
    rst_n = 1'b0; req_en = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    dat_i = '0; ack_en = 1'b0; err_en = 1'b0; b_req_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", {30'h0, cyc_o, stb_o}, 32'h0);
    chk("rst_ack", {26'h0, req_ack, req_err}, 32'h0);
    chk("rst_sel", {28'h0, sel_o}, 32'h0);
    chk("rst_rd0", req_rdata[31:0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ch1 byte write, zero-wait slave
    ack_en = 1'b1;
    set_ch(1, 1'b1, 2'd0, 32'h0000_0001, 32'h0000_00AF);
    @(negedge clk);
    chk("bw_cyc",  {31'h0, cyc_o & stb_o}, 32'h1);
    chk("bw_we",   {31'h0, we_o}, 32'h1);
    chk("bw_adr",  {2'b0, adr_o}, 32'h0);
    chk("bw_sel",  {28'h0, sel_o}, 32'h2);
    chk("bw_dat",  dat_o, 32'hAFAF_AFAF);
    chk("bw_stl",  {29'h0, req_stl}, 32'h2);
    @(negedge clk);
    chk("bw_ack",  {29'h0, req_ack}, 32'h2);
    chk("bw_err",  {29'h0, req_err}, 32'h0);
    req_en = '0;
    @(negedge clk);
    chk("bw_idle", {31'h0, cyc_o}, 32'h0);

    // Ch0 reads: byte, half, word
    dat_i = 32'h1234_AF78;
    set_ch(0, 1'b0, 2'd0, 32'h0000_0001, 32'h0);
    @(negedge clk);
    chk("br_sel", {28'h0, sel_o}, 32'h2);
    chk("br_we",  {31'h0, we_o}, 32'h0);
    @(negedge clk);
    chk("br_ack", {29'h0, req_ack}, 32'h1);
    chk("br_rd",  req_rdata[31:0], 32'h0000_00AF);
    req_en = '0;
    @(negedge clk);
    set_ch(0, 1'b0, 2'd1, 32'h0000_0002, 32'h0);
    @(negedge clk);
    chk("hr_sel", {28'h0, sel_o}, 32'hC);
    @(negedge clk);
    chk("hr_rd",  req_rdata[31:0], 32'h0000_1234);
    req_en = '0;
    @(negedge clk);
    dat_i = 32'hDEAD_BEEF;
    set_ch(0, 1'b0, 2'd2, 32'h0000_0004, 32'h0);
    @(negedge clk);
    chk("wr_adr", {2'b0, adr_o}, 32'h1);
    chk("wr_sel", {28'h0, sel_o}, 32'hF);
    @(negedge clk);
    chk("wr_rd",  req_rdata[31:0], 32'hDEAD_BEEF);
    req_en = '0;
    dat_i = 32'h0;
    repeat (2) @(negedge clk);
    chk("rd_hold", req_rdata[31:0], 32'hDEAD_BEEF);
    chk("rd_ch1",  req_rdata[63:32], 32'h0);

    // Misaligned half and reserved size on ch2: no bus cycle
    set_ch(2, 1'b0, 2'd1, 32'h0000_0003, 32'h0);
    @(negedge clk);
    chk("mis_ack", {29'h0, req_ack}, 32'h4);
    chk("mis_err", {29'h0, req_err}, 32'h4);
    chk("mis_cyc", {31'h0, cyc_o}, 32'h0);
    req_en = '0;
    repeat (2) @(negedge clk);
    set_ch(2, 1'b0, 2'd3, 32'h0000_0000, 32'h0);
    @(negedge clk);
    chk("rsv_ack", {29'h0, req_ack}, 32'h4);
    chk("rsv_err", {29'h0, req_err}, 32'h4);
    chk("rsv_cyc", {31'h0, cyc_o}, 32'h0);
    chk("rsv_rd",  req_rdata[95:64], 32'h0);
    req_en = '0;
    repeat (2) @(negedge clk);

    // Silent slave: timeout after 4 BUS cycles
    ack_en = 1'b0;
    set_ch(0, 1'b0, 2'd2, 32'h0000_0008, 32'h0);
    cnt = 0; found = 1'b0; err_seen = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cyc_o) cnt++;
      if (req_ack[0]) begin
        found    = 1'b1;
        err_seen = req_err;
      end
    end
    chk("to_seen", {31'h0, found}, 32'h1);
    chk("to_cyc",  cnt, 32'd4);
    chk("to_err",  {29'h0, err_seen}, 32'h1);
    chk("to_rd",   req_rdata[31:0], 32'hDEAD_BEEF);
    req_en = '0;
    repeat (2) @(negedge clk);

    // err_i together with ack_i
    ack_en = 1'b1; err_en = 1'b1; dat_i = 32'h5555_5555;
    set_ch(0, 1'b0, 2'd2, 32'h0000_0000, 32'h0);
    repeat (2) @(negedge clk);
    chk("be_ack", {29'h0, req_ack}, 32'h1);
    chk("be_err", {29'h0, req_err}, 32'h1);
    chk("be_rd",  req_rdata[31:0], 32'hDEAD_BEEF);
    req_en = '0; err_en = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed priority with all channels requesting
    for (int unsigned c = 0; c < 3; c++) set_ch(c, 1'b0, 2'd2, 32'h0, 32'h0);
    k = 0;
    for (int unsigned i = 0; i < 30 && k < 3; i++) begin
      @(negedge clk);
      if (req_ack != 3'b000) begin
        seq[k] = req_ack; when[k] = i; k++;
      end
    end
    req_en = '0;
    chk("fx_cnt", k, 32'd3);
    for (int unsigned i = 0; i < 3; i++) chk($sformatf("fx_g%0d", i), {29'h0, seq[i]}, 32'h1);
    chk("fx_gap", when[1] - when[0], 32'd3);
    repeat (3) @(negedge clk);

    // Round-robin with all channels requesting
    b_req_en = 3'b111;
    k = 0;
    for (int unsigned i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (b_ack != 3'b000) begin
        seq[k] = b_ack; k++;
      end
    end
    b_req_en = '0;
    chk("rr_cnt", k, 32'd4);
    chk("rr_g0", {29'h0, seq[0]}, 32'h1);
    chk("rr_g1", {29'h0, seq[1]}, 32'h2);
    chk("rr_g2", {29'h0, seq[2]}, 32'h4);
    chk("rr_g3", {29'h0, seq[3]}, 32'h1);
    repeat (3) @(negedge clk);

    // Reset asserted mid-BUS
    ack_en = 1'b0;
    set_ch(0, 1'b0, 2'd2, 32'h0000_0000, 32'h0);
    @(negedge clk);
    chk("mr_pre", {31'h0, cyc_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_cyc", {30'h0, cyc_o, stb_o}, 32'h0);
    chk("mr_ack", {26'h0, req_ack, req_err}, 32'h0);
    chk("mr_rd",  req_rdata[31:0], 32'h0);
    chk("mr_adr", {2'b0, adr_o}, 32'h0);
    req_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
